// File: rtl/stream_merge_2_rr.sv
// stream_merge_2_rr: two-source round-robin stream merger with packet locking and a registered output stage
module stream_merge_2_rr #(
  parameter int DATA_WIDTH   = 8,
  parameter bit LOCK_ON_LAST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  true_valid,
  input  logic [DATA_WIDTH-1:0] true_data,
  input  logic                  true_last,
  output logic                  true_ready,
  input  logic                  false_valid,
  input  logic [DATA_WIDTH-1:0] false_data,
  input  logic                  false_last,
  output logic                  false_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  bit_select,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, LOCK_TRUE, LOCK_FALSE} state_t;
  state_t state;
  logic   ptr;
  logic   space, cand_true, cand_false, true_acc, false_acc;
  always_comb begin
    space       = !out_valid | out_ready;
    cand_true   = true_valid & (!false_valid | ptr);
    cand_false  = false_valid & (!true_valid | !ptr);
    true_ready  = !reset & space & ((state == IDLE) ? cand_true : (state == LOCK_TRUE));
    false_ready = !reset & space & ((state == IDLE) ? cand_false : (state == LOCK_FALSE));
    true_acc    = true_valid & true_ready;
    false_acc   = false_valid & false_ready;
    busy        = state != IDLE;
  end
  // ptr = 1 favours the true source on a tie; it flips to the loser after every accept
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      bit_select <= 1'b0;
    end else begin
      if (true_acc | false_acc) begin
        out_valid  <= 1'b1;
        out_data   <= true_acc ? true_data : false_data;
        out_last   <= true_acc ? true_last : false_last;
        bit_select <= true_acc;
        ptr        <= false_acc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (LOCK_ON_LAST) begin
        if (true_acc) state <= true_last ? IDLE : LOCK_TRUE;
        else if (false_acc) state <= false_last ? IDLE : LOCK_FALSE;
      end
    end
  end
endmodule

// File: doc/stream_merge_2_rr.md
Name: stream_merge_2_rr

Overview:
- Two-source stream merger with round-robin arbitration and packet locking; sits directly upstream of the 2-way select stage.
- Accepts beats from a "true" and a "false" valid/ready channel and registers the winning beat into a single output stage.
- Exports the registered source select as `bit_select` (1 = true source, 0 = false source).
- The downstream select stage and any sideband muxing consume `bit_select` aligned with `out_data`.

Parameters:
- `DATA_WIDTH`, 8: width of `true_data`, `false_data` and `out_data`.
- `LOCK_ON_LAST`, 1: 1 = grant held from first beat until a beat with last=1 is accepted; 0 = arbitrate on every beat.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `true_valid` in 1: true source has a beat.
- `true_data` in DATA_WIDTH: true source payload.
- `true_last` in 1: final beat of a true-source packet.
- `true_ready` out 1: true beat accepted this cycle when high with `true_valid`.
- `false_valid` in 1: false source has a beat.
- `false_data` in DATA_WIDTH: false source payload.
- `false_last` in 1: final beat of a false-source packet.
- `false_ready` out 1: false beat accepted this cycle when high with `false_valid`.
- `out_valid` out 1: output register holds a beat.
- `out_data` out DATA_WIDTH: registered payload.
- `out_last` out 1: registered last flag.
- `out_ready` in 1: downstream accepts the output beat.
- `bit_select` out 1: source of the beat in the output register (1 = true, 0 = false).
- `busy` out 1: high while a packet is locked (LOCK_TRUE or LOCK_FALSE).

Behaviour:
- Reset (synchronous, active-high, clock edge with `reset`=1):
  - `out_valid`=0, `out_data`=0, `out_last`=0, `bit_select`=0, `busy`=0.
  - State=IDLE; priority pointer = "true first".
  - `true_ready`=`false_ready`=0 while `reset` is high.
- `space` = !`out_valid` | `out_ready`. The output stage can load in the same cycle it drains.
- States:
  - IDLE: candidate chosen combinationally.
    - Only one valid source: that source.
    - Both valid: source indicated by pointer.
    - Neither valid: no grant.
  - LOCK_TRUE: only the true source is eligible. The false source is starved even if `true_valid`=0.
  - LOCK_FALSE: mirror of LOCK_TRUE.
- Ready outputs:
  - `true_ready` = `space` & (true is candidate in IDLE, or state=LOCK_TRUE).
  - `false_ready` likewise.
  - At most one ready is high per cycle.
  - Ready does not depend on the source's own valid beyond candidate selection in IDLE.
- Accept: on valid&ready for a source:
  - `out_data`/`out_last` are loaded from that source and `out_valid`=1.
  - `bit_select` = source.
  - Pointer is set to favour the other source.
- Drain without load: when `out_valid`&`out_ready` and no accept, `out_valid`->0. `out_data`, `out_last` and `bit_select` hold their last value.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `bit_select` are stable and both readies are 0.
- Transitions, LOCK_ON_LAST=1:
  - IDLE -> LOCK_x on accept from x with last=0.
  - IDLE stays on accept with last=1 (single-beat packet).
  - LOCK_x -> IDLE on accept from x with last=1.
  - No other transitions.
- Transitions, LOCK_ON_LAST=0: state stays IDLE; `busy`=0 permanently.
- Latency and throughput: accept in cycle N -> `out_valid` in N+1. Sustained throughput is 1 beat/cycle when `out_ready`=1.
- Reset mid-packet: lock is dropped and the output beat is discarded. The source must restart its packet; no recovery is attempted.
- Last=1 on a beat that is not accepted has no effect.

Test Plan:
- Reset, then hold `reset`=1 with both valids high -> both readies 0, `out_valid`=0, `bit_select`=0.
- True only, 3 beats 0x11/0x22/0x33, last on 3rd, `out_ready`=1 -> `out_data` 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept. `bit_select`=1 and `busy`=1 until the cycle after the 0x33 accept.
- Both valid, single-beat packets (last=1 always), true=0xA0, false=0xB0, `out_ready`=1 -> output alternates 0xA0,0xB0,0xA0,… with `bit_select` 1,0,1,…; true wins first.
- Lock: false sends a 4-beat packet; true valid from beat 2; false deasserts valid for 2 cycles mid-packet -> `true_ready` stays 0 throughout. True's first beat appears only after the false last beat; no interleave.
- Backpressure: `out_ready`=0 for 3 cycles with a beat 0x5C held -> `out_valid`=1, `out_data`=0x5C stable, both readies 0. `out_ready`=1 -> drain and load of the next beat in the same cycle.
- Reset asserted one cycle during LOCK_TRUE -> next cycle `busy`=0, `out_valid`=0, state IDLE. A false single beat is then accepted immediately.
